// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE program sequencer: instruction
// opcodes, PE pipeline opcodes, FSM states, error codes and the layout of
// the 16-bit instruction word {4'b0, addr[7:0], opcode[3:0]}.
package pe_seq_pkg;

  // Instruction opcodes; encodings 11..15 are illegal.
  typedef enum logic [3:0] {
    OP_NOOP          = 4'd0,
    OP_FETCH_A       = 4'd1,
    OP_FETCH_B       = 4'd2,
    OP_ADD           = 4'd3,
    OP_SUB           = 4'd4,
    OP_MUL           = 4'd5,
    OP_DOTP          = 4'd6,
    OP_STORE_TEMP_S1 = 4'd7,
    OP_STORE_TEMP_S2 = 4'd8,
    OP_STORE_RESULT  = 4'd9,
    OP_STOP          = 4'd10
  } opcode_e;

  // Opcodes understood by the two-stage PE pipeline.
  typedef enum logic [2:0] {
    PE_NONE = 3'd0,
    PE_ADD  = 3'd1,
    PE_SUB  = 3'd2,
    PE_MUL  = 3'd3,
    PE_DOTP = 3'd4
  } pe_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_WAIT_PE = 3'd3,
    S_FINISH  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL    = 2'd1;
  localparam logic [1:0] ERR_PC_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  // Instruction word field positions.
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 4;
  localparam int ADDR_LSB = 4;
  localparam int ADDR_W   = 8;

  // Maps an arithmetic instruction onto the PE pipeline opcode.
  function automatic pe_op_e pe_op_of(input logic [3:0] opc);
    case (opc)
      OP_ADD:  return PE_ADD;
      OP_SUB:  return PE_SUB;
      OP_MUL:  return PE_MUL;
      OP_DOTP: return PE_DOTP;
      default: return PE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pe_seq_ctrl.sv
// Program sequencer for the SIMD PE datapath. Fetches and decodes one
// instruction per two cycles, drives data RAM reads/writes and PE issue,
// and stalls on the selected PE stage valid.
// Optional PE wait watchdog: define PE_SEQ_TIMEOUT_EN to enable it.
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int INST_DEPTH     = 256,
  parameter int DRAM_DEPTH     = 256,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IADDR_W       = $clog2(INST_DEPTH),
  localparam int DADDR_W       = $clog2(DRAM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               inst_ren,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [15:0]        inst_rdata,
  output logic               dram_a_ren,
  output logic               dram_b_ren,
  output logic [DADDR_W-1:0] dram_raddr,
  output logic               dram_wen,
  output logic [DADDR_W-1:0] dram_waddr,
  output logic               pe_issue,
  output logic [2:0]         pe_opcode,
  input  logic               pe_stage_1_valid,
  input  logic               pe_stage_2_valid,
  output logic               temp_store,
  output logic               temp_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [IADDR_W-1:0] PC_LAST = IADDR_W'(INST_DEPTH - 1);

  state_e             state_reg, state_next;
  logic [IADDR_W-1:0] pc_reg, pc_next;
  logic               err_reg, err_next;
  logic [1:0]         err_code_reg, err_code_next;
  logic               res_valid_reg, res_valid_next;
  logic               wait_sel_reg, wait_sel_next;   // 0: stage 1, 1: stage 2
  logic               advance;
  logic               sel_valid;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] addr_field;
  logic              unused_inst_bits;

  assign opcode           = inst_rdata[OPC_LSB +: OPC_W];
  assign addr_field       = inst_rdata[ADDR_LSB +: ADDR_W];
  assign unused_inst_bits = ^{inst_rdata[15:12], addr_field};

  assign inst_addr = pc_reg;
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_WAIT_PE);
  assign err       = err_reg;
  assign err_code  = err_code_reg;

  // State and program-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
      res_valid_reg <= 1'b0;
      wait_sel_reg  <= 1'b0;
`ifdef PE_SEQ_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      res_valid_reg <= res_valid_next;
      wait_sel_reg  <= wait_sel_next;
`ifdef PE_SEQ_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  // Next-state logic and single-cycle strobes decoded from state and opcode.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    err_next       = err_reg;
    err_code_next  = err_code_reg;
    res_valid_next = res_valid_reg;
    wait_sel_next  = wait_sel_reg;
`ifdef PE_SEQ_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif
    advance    = 1'b0;
    sel_valid  = 1'b0;
    inst_ren   = 1'b0;
    dram_a_ren = 1'b0;
    dram_b_ren = 1'b0;
    dram_raddr = '0;
    dram_wen   = 1'b0;
    dram_waddr = '0;
    pe_issue   = 1'b0;
    pe_opcode  = PE_NONE;
    temp_store = 1'b0;
    temp_sel   = 1'b0;
    done       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          pc_next        = '0;
          err_next       = 1'b0;
          err_code_next  = ERR_NONE;
          res_valid_next = 1'b0;
          state_next     = S_FETCH;
        end
      end
      S_FETCH: begin
        inst_ren   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_NOOP: advance = 1'b1;
          OP_FETCH_A: begin
            dram_a_ren = 1'b1;
            dram_raddr = addr_field[DADDR_W-1:0];
            advance    = 1'b1;
          end
          OP_FETCH_B: begin
            dram_b_ren = 1'b1;
            dram_raddr = addr_field[DADDR_W-1:0];
            advance    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_MUL, OP_DOTP: begin
            pe_issue      = 1'b1;
            pe_opcode     = pe_op_of(opcode);
            wait_sel_next = (opcode == OP_DOTP);
`ifdef PE_SEQ_TIMEOUT_EN
            wait_cnt_next = '0;
`endif
            state_next    = S_WAIT_PE;
          end
          OP_STORE_TEMP_S1: begin
            temp_store = 1'b1;
            advance    = 1'b1;
          end
          OP_STORE_TEMP_S2: begin
            temp_store = 1'b1;
            temp_sel   = 1'b1;
            advance    = 1'b1;
          end
          OP_STORE_RESULT: begin
            // Issued even without a fresh result: the stale temp is written.
            dram_wen       = 1'b1;
            dram_waddr     = addr_field[DADDR_W-1:0];
            res_valid_next = 1'b0;
            advance        = 1'b1;
          end
          OP_STOP: state_next = S_FINISH;
          default: begin
            err_next      = 1'b1;
            err_code_next = ERR_ILLEGAL;
            state_next    = S_FINISH;
          end
        endcase
      end
      S_WAIT_PE: begin
        sel_valid = wait_sel_reg ? pe_stage_2_valid : pe_stage_1_valid;
        if (sel_valid) begin
          res_valid_next = 1'b1;
          advance        = 1'b1;
        end
`ifdef PE_SEQ_TIMEOUT_EN
        // A valid arriving on the last allowed cycle takes priority.
        else if (wait_cnt_reg == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = S_FINISH;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
`endif
      end
      S_FINISH: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Step to the next instruction; running off the end of the RAM is an error.
    if (advance) begin
      if (pc_reg == PC_LAST) begin
        err_next      = 1'b1;
        err_code_next = ERR_PC_OVERRUN;
        state_next    = S_FINISH;
      end else begin
        pc_next    = pc_reg + 1'b1;
        state_next = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl: models the instruction RAM and the PE
// stage-valid timing, and checks every strobe against a scoreboard of
// expected events pushed when each program is loaded.
module tb_pe_seq_ctrl;
  import pe_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       inst_ren;
  logic [7:0] inst_addr;
  logic [15:0] inst_rdata = 16'h0;
  logic       dram_a_ren, dram_b_ren, dram_wen;
  logic [7:0] dram_raddr, dram_waddr;
  logic       pe_issue;
  logic [2:0] pe_opcode;
  logic       pe_stage_1_valid = 1'b0;
  logic       pe_stage_2_valid = 1'b0;
  logic       temp_store, temp_sel, busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  pe_seq_ctrl #(.INST_DEPTH(256), .DRAM_DEPTH(256), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .dram_a_ren(dram_a_ren), .dram_b_ren(dram_b_ren), .dram_raddr(dram_raddr),
    .dram_wen(dram_wen), .dram_waddr(dram_waddr),
    .pe_issue(pe_issue), .pe_opcode(pe_opcode),
    .pe_stage_1_valid(pe_stage_1_valid), .pe_stage_2_valid(pe_stage_2_valid),
    .temp_store(temp_store), .temp_sel(temp_sel),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  localparam logic [3:0] EV_A = 4'd1, EV_B = 4'd2, EV_ISSUE = 4'd3;
  localparam logic [3:0] EV_TS = 4'd4, EV_WEN = 4'd5, EV_DONE = 4'd6;

  logic [15:0] imem [256];
  logic [15:0] sb [$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, done_cyc = -1;
  int cfg_s1 = 0, cfg_s2 = 0, s1_cnt = 0, s2_cnt = 0;
  int max_iaddr = -1, first_addr = -1;
  logic done_seen = 1'b0, seen_last = 1'b0, wrapped = 1'b0;

  function automatic logic [15:0] ev(input logic [3:0] k, input logic [11:0] v);
    return {k, v};
  endfunction

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] a);
    return {4'b0, a, op};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input logic [15:0] obs);
    logic [15:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
    check("scoreboard", {48'b0, obs}, {48'b0, exp});
  endtask

  function automatic logic [63:0] all_outputs();
    return {14'b0, inst_ren, inst_addr, dram_a_ren, dram_b_ren, dram_raddr,
            dram_wen, dram_waddr, pe_issue, pe_opcode, temp_store, temp_sel,
            busy, done, err, err_code};
  endfunction

  // One clock: sample at negedge, model instruction RAM and PE, score strobes.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (inst_ren) begin
      if (seen_last && inst_addr == 8'h00) wrapped = 1'b1;
      if (inst_addr == 8'hFF) seen_last = 1'b1;
      if (int'(inst_addr) > max_iaddr) max_iaddr = int'(inst_addr);
      if (first_addr < 0) first_addr = int'(inst_addr);
      inst_rdata = imem[inst_addr];
    end
    if (dram_a_ren) observe(ev(EV_A, {4'b0, dram_raddr}));
    if (dram_b_ren) observe(ev(EV_B, {4'b0, dram_raddr}));
    if (pe_issue)   observe(ev(EV_ISSUE, {9'b0, pe_opcode}));
    if (temp_store) observe(ev(EV_TS, {11'b0, temp_sel}));
    if (dram_wen)   observe(ev(EV_WEN, {4'b0, dram_waddr}));
    if (done) begin
      observe(ev(EV_DONE, {9'b0, err, err_code}));
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    pe_stage_1_valid = 1'b0;
    pe_stage_2_valid = 1'b0;
    if (pe_issue) begin
      s1_cnt = cfg_s1;
      s2_cnt = cfg_s2;
    end else begin
      if (s1_cnt > 0) begin s1_cnt--; pe_stage_1_valid = (s1_cnt == 0); end
      if (s2_cnt > 0) begin s2_cnt--; pe_stage_2_valid = (s2_cnt == 0); end
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0;
  endtask

  task automatic start_prog();
    done_seen = 1'b0; done_cyc = -1; seen_last = 1'b0; wrapped = 1'b0;
    max_iaddr = -1; first_addr = -1;
    start_cyc = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs a loaded program to done; restart_at injects a stray start pulse.
  task automatic run(input string tag, input int budget, input int exp_lat,
                     input logic [2:0] exp_status, input int restart_at);
    int n;
    start_prog();
    n = 0;
    while (!done_seen && n < budget) begin
      if (n == restart_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
    end
    check({tag, "_done_seen"}, {63'b0, done_seen}, 64'd1);
    check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(exp_lat));
    check({tag, "_first_pc"}, 64'(first_addr), 64'd0);
    step();
    check({tag, "_idle_status"}, {61'b0, busy, err, err_code}, {61'b0, 1'b0, exp_status});
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic load_prog1();
    clear_imem();
    imem[0] = ins(OP_FETCH_A, 8'h12);
    imem[1] = ins(OP_FETCH_B, 8'h34);
    imem[2] = ins(OP_ADD, 8'h00);
    imem[3] = ins(OP_STORE_TEMP_S1, 8'h00);
    imem[4] = ins(OP_STORE_RESULT, 8'h56);
    imem[5] = ins(OP_STOP, 8'h00);
    sb.push_back(ev(EV_A, 12'h012));
    sb.push_back(ev(EV_B, 12'h034));
    sb.push_back(ev(EV_ISSUE, 12'd1));
    sb.push_back(ev(EV_TS, 12'd0));
    sb.push_back(ev(EV_WEN, 12'h056));
    sb.push_back(ev(EV_DONE, 12'h000));
    cfg_s1 = 1; cfg_s2 = 0;
  endtask

  initial begin
    clear_imem();
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    step();
    check("idle_outputs", all_outputs(), 64'd0);

    // Basic ADD program, valid one cycle after issue
    load_prog1();
    run("add_prog", 40, 14, 3'b000, -1);

    // Illegal opcode 4'hC at pc=3: error finish, no write
    clear_imem();
    imem[3] = 16'h000C;
    imem[4] = ins(OP_STORE_RESULT, 8'h10);
    imem[5] = ins(OP_STOP, 8'h00);
    sb.push_back(ev(EV_DONE, {9'b0, 1'b1, ERR_ILLEGAL}));
    run("illegal_op", 40, 9, {1'b1, ERR_ILLEGAL}, -1);

    // DOTP waits on stage 2 (5 cycles), ignores stray stage-1 valid and a
    // start pulse while busy; err from the previous run is cleared
    clear_imem();
    imem[0] = ins(OP_FETCH_A, 8'h01);
    imem[1] = ins(OP_FETCH_B, 8'h02);
    imem[2] = ins(OP_DOTP, 8'h00);
    imem[3] = ins(OP_STORE_TEMP_S2, 8'h00);
    imem[4] = ins(OP_STORE_RESULT, 8'h03);
    imem[5] = ins(OP_STOP, 8'h00);
    sb.push_back(ev(EV_A, 12'h001));
    sb.push_back(ev(EV_B, 12'h002));
    sb.push_back(ev(EV_ISSUE, 12'd4));
    sb.push_back(ev(EV_TS, 12'd1));
    sb.push_back(ev(EV_WEN, 12'h003));
    sb.push_back(ev(EV_DONE, 12'h000));
    cfg_s1 = 2; cfg_s2 = 5;
    run("dotp_prog", 60, 18, 3'b000, 7);

    // 256 NOOPs with no STOP: pc overrun, no wrap
    clear_imem();
    sb.push_back(ev(EV_DONE, {9'b0, 1'b1, ERR_PC_OVERRUN}));
    cfg_s1 = 0; cfg_s2 = 0;
    run("pc_overrun", 600, 513, {1'b1, ERR_PC_OVERRUN}, -1);
    check("overrun_no_wrap", {63'b0, wrapped}, 64'd0);
    check("overrun_max_pc", 64'(max_iaddr), 64'd255);

    // Reset while waiting on the PE
    clear_imem();
    imem[0] = ins(OP_ADD, 8'h00);
    imem[1] = ins(OP_STOP, 8'h00);
    sb.push_back(ev(EV_ISSUE, 12'd1));
    cfg_s1 = 0; cfg_s2 = 0;
    start_prog();
    step();
    step();
    check("wait_pe_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    step();
    check("midrun_reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    step();
    check("midrun_reset_no_done", {63'b0, done_seen}, 64'd0);
    check("midrun_sb_empty", 64'(sb.size()), 64'd0);

    // Fresh start after reset runs from pc=0
    load_prog1();
    run("rerun_prog", 40, 14, 3'b000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
